// File: rtl/seq_pkg.sv
// Shared types and helpers for the start sequencer: controller state encoding,
// frame counter width and FIFO pointer width.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Wide enough for the largest supported frame length (65535 words).
    localparam int CNT_W = 16;

    // One extra bit beyond the address so full and empty differ only in the MSB.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read, wrap-bit full/empty detection
// and a sticky overflow flag for writes dropped while full.
module sync_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + PW'(1);
            end
            if (wr_en && !do_wr) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/start_sequencer.sv
// Frame sender: on go, requests a start from the downstream wait stage, then
// streams FRAME_LEN words out of the internal FIFO and pulses done.
module start_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = 16,
    parameter int DEPTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             go,
    input  logic             start_ack,
    input  logic             m_ready,
    output logic             ex_start,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             full,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] word_cnt;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_head),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    // m_valid/m_ready: a word moves only on a cycle where both are high; while
    // m_valid is high and m_ready low, m_valid and m_data hold their values.
    assign m_valid = (state == ST_SEND) && !fifo_empty;
    assign fifo_rd = m_valid && m_ready;
    assign m_last  = m_valid && (word_cnt == LAST_IDX);
    assign m_data  = m_valid ? fifo_head : '0;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            ex_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        state    <= ST_REQ;
                        ex_start <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (start_ack) begin
                        state    <= ST_SEND;
                        ex_start <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (fifo_rd) begin
                        if (word_cnt == LAST_IDX) begin
                            word_cnt <= '0;
                            state    <= ST_DONE;
                            done     <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: a cycle-by-cycle vector table for the basic
// handshake, then directed multi-cycle frame sequences with a data queue.
module tb_start_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        go;
    logic        start_ack;
    logic        m_ready;
    logic        ex_start;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        full;
    logic        overflow;

    int          n_vec;
    int          n_bad;
    logic [31:0] exp_q[$];

    start_sequencer #(
        .WIDTH     (32),
        .FRAME_LEN (16),
        .DEPTH     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .go        (go),
        .start_ack (start_ack),
        .m_ready   (m_ready),
        .ex_start  (ex_start),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    typedef struct packed {
        logic        rst;
        logic        wr_en;
        logic [31:0] wr_data;
        logic        go;
        logic        ack;
        logic        rdy;
        logic        e_ex;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample 1 ns later.
    task automatic step(input logic w, input logic [31:0] d, input logic g,
                        input logic a, input logic r);
        @(negedge clk);
        wr_en     = w;
        wr_data   = d;
        go        = g;
        start_ack = a;
        m_ready   = r;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        go        = 1'b0;
        start_ack = 1'b0;
        m_ready   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_ex"}, ex_start, 1'b0);
        check1({tag, "_valid"}, m_valid, 1'b0);
        check32({tag, "_data"}, m_data, 32'h0);
        check1({tag, "_last"}, m_last, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_full"}, full, 1'b0);
        check1({tag, "_ovf"}, overflow, 1'b0);
    endtask

    // mode 0: ready always, 1: ready toggles, 2: go pulsed mid-frame,
    // 3: preload only part of the frame and trickle the rest in.
    task automatic frame_test(input int mode, input int preload_n, input int abort_at,
                              input logic [31:0] base);
        int          cyc;
        int          acc;
        int          wi;
        int          ex_cnt;
        int          done_cnt;
        logic        w;
        logic        g;
        logic        r;
        logic [31:0] d;

        for (int i = 0; i < preload_n; i++) begin
            step(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b0);
            check1("full_pre", full, i >= 16);
            check1("ovf_pre", overflow, i >= 17);
            if (i < 16) exp_q.push_back(base + 32'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check1("full_loaded", full, preload_n >= 16);
        check1("ovf_loaded", overflow, preload_n > 16);
        check1("idle_valid", m_valid, 1'b0);
        check1("idle_busy", busy, 1'b0);

        ex_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b0, k == 2, 1'b0);
            check1("req_valid", m_valid, 1'b0);
            check1("req_busy", busy, 1'b1);
            if (ex_start) ex_cnt++;
        end
        check32("ex_start_cycles", 32'(ex_cnt), 32'd3);

        cyc      = 0;
        acc      = 0;
        wi       = preload_n;
        done_cnt = 0;
        while (acc < 16 && cyc < 200) begin
            w = 1'b0;
            g = 1'b0;
            d = '0;
            r = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            if (mode == 2 && cyc == 4) g = 1'b1;
            if (mode == 3 && wi < 16 && (cyc % 3) == 2) begin
                w = 1'b1;
                d = base + 32'(wi);
            end
            step(w, d, g, 1'b0, r);
            check1("send_valid", m_valid, exp_q.size() != 0);
            check1("send_ex", ex_start, 1'b0);
            if (m_valid && exp_q.size() != 0) begin
                check32("send_data", m_data, exp_q[0]);
                check1("send_last", m_last, acc == 15);
            end
            if (done) done_cnt++;
            if (m_valid && r && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                acc++;
            end
            if (w) begin
                exp_q.push_back(d);
                wi++;
            end
            cyc++;
            if (abort_at != 0 && acc == abort_at) break;
        end

        if (abort_at != 0) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check_all_zero("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            for (int k = 0; k < 3; k++) begin
                step(1'b0, '0, 1'b0, 1'b0, 1'b1);
                check1("post_rst_done", done, 1'b0);
                check1("post_rst_busy", busy, 1'b0);
                check1("post_rst_valid", m_valid, 1'b0);
            end
            check1("post_rst_empty", dut.u_fifo.empty, 1'b1);
            check1("post_rst_full", full, 1'b0);
        end else begin
            check32("frame_words", 32'(acc), 32'd16);
            if (mode == 0) check32("frame_cycles", 32'(cyc), 32'd16);
            check32("done_early", 32'(done_cnt), 32'd0);
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check1("done_pulse", done, 1'b1);
            check1("done_busy", busy, 1'b1);
            check1("done_valid", m_valid, 1'b0);
            if (done) done_cnt++;
            for (int k = 0; k < 4; k++) begin
                step(1'b0, '0, 1'b0, 1'b0, 1'b1);
                check1("after_busy", busy, 1'b0);
                check1("after_ex", ex_start, 1'b0);
                if (done) done_cnt++;
            end
            check32("done_count", 32'(done_cnt), 32'd1);
            check1("after_empty", dut.u_fifo.empty, 1'b1);
            check1("after_full", full, 1'b0);
            check1("after_ovf", overflow, preload_n > 16);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        go        = 1'b0;
        start_ack = 1'b0;
        m_ready   = 1'b0;

        //            rst  wr    wr_data      go   ack  rdy  ex   vld  data         lst  bsy  dn   ful  ovf
        vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h000000a0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h000000a1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b1,1'b1,1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b1,32'h000000a0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b1,1'b0,1'b1,32'h000000a0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b1,1'b0,1'b1,32'h000000a1,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,       1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            wr_en     = vecs[i].wr_en;
            wr_data   = vecs[i].wr_data;
            go        = vecs[i].go;
            start_ack = vecs[i].ack;
            m_ready   = vecs[i].rdy;
            #1;
            check1($sformatf("v%0d_ex", i), ex_start, vecs[i].e_ex);
            check1($sformatf("v%0d_valid", i), m_valid, vecs[i].e_valid);
            check32($sformatf("v%0d_data", i), m_data, vecs[i].e_data);
            check1($sformatf("v%0d_last", i), m_last, vecs[i].e_last);
            check1($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check1($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check1($sformatf("v%0d_full", i), full, vecs[i].e_full);
            check1($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
        end

        reset_dut();
        frame_test(0, 16, 0, 32'h0);
        reset_dut();
        frame_test(1, 16, 0, 32'h0);
        reset_dut();
        frame_test(3, 4, 0, 32'h0);
        reset_dut();
        frame_test(0, 17, 0, 32'h100);
        reset_dut();
        frame_test(0, 16, 5, 32'h0);
        reset_dut();
        frame_test(2, 16, 0, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
